// File: rtl/gsu_window_map.sv
// Programmable SNES-to-SRAM0 window decoder. Up to eight MCU-configured windows
// are matched in parallel and the lowest-indexed hit wins. The decode runs
// through a two-stage pipeline. A settle counter reports when the outputs
// describe an address that has been held stable.
module gsu_window_map #(
  parameter int unsigned NUM_WIN = 4,
  parameter int unsigned SETTLE  = 3,
  parameter int unsigned IDX_W   = 2
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [2:0]         cfg_sel,
  input  logic [23:0]        cfg_data,
  input  logic [23:0]        SNES_ADDR,
  input  logic               SNES_ROMSEL,
  output logic [23:0]        ROM_ADDR,
  output logic               ROM_HIT,
  output logic               IS_SAVERAM,
  output logic               IS_WRITABLE,
  output logic [NUM_WIN-1:0] win_hit,
  output logic               addr_valid
);

  localparam int unsigned CntW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CntW-1:0] SettleVal = CntW'(SETTLE);

  // Per-window configuration
  logic [23:0] match_val_q  [NUM_WIN];
  logic [23:0] match_mask_q [NUM_WIN];
  logic [23:0] addr_mask_q  [NUM_WIN];
  logic [23:0] offset_q     [NUM_WIN];
  logic [3:0]  ctrl_q       [NUM_WIN];

  // Stage 1
  logic [23:0]        a1_q;
  logic               r1_q;
  logic [NUM_WIN-1:0] match_q, match_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  // Stage 2
  logic [23:0]        rom_addr_q, rom_addr_d;
  logic               rom_hit_q, rom_hit_d;
  logic               saveram_q, saveram_d;
  logic               writable_q, writable_d;
  logic [NUM_WIN-1:0] win_hit_q, win_hit_d;
  logic               addr_valid_q;

  logic cfg_ok;
  assign cfg_ok = cfg_we && (32'(cfg_idx) < NUM_WIN) && (cfg_sel <= 3'd4);

  // Configuration register file, written one field per strobe
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_WIN; i++) begin
        match_val_q[i]  <= '0;
        match_mask_q[i] <= '0;
        addr_mask_q[i]  <= '0;
        offset_q[i]     <= '0;
        ctrl_q[i]       <= '0;
      end
    end else if (cfg_ok) begin
      for (int i = 0; i < NUM_WIN; i++) begin
        if (cfg_idx == IDX_W'(i)) begin
          case (cfg_sel)
            3'd0:    match_val_q[i]  <= cfg_data;
            3'd1:    match_mask_q[i] <= cfg_data;
            3'd2:    addr_mask_q[i]  <= cfg_data;
            3'd3:    offset_q[i]     <= cfg_data;
            3'd4:    ctrl_q[i]       <= cfg_data[3:0];
            default: ;
          endcase
        end
      end
    end
  end

  // Per-window match on the live bus address and settle counter next state
  always_comb begin
    match_d = '0;
    for (int i = 0; i < NUM_WIN; i++) begin
      match_d[i] = ctrl_q[i][0]
                   && ((SNES_ADDR & match_mask_q[i]) == (match_val_q[i] & match_mask_q[i]))
                   && (!ctrl_q[i][3] || !SNES_ROMSEL);
    end
    cnt_d = cnt_q;
    if (cfg_ok || (SNES_ADDR != a1_q)) begin
      cnt_d = '0;
    end else if (cnt_q != SettleVal) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Stage 1 registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a1_q    <= '0;
      r1_q    <= 1'b0;
      match_q <= '0;
      cnt_q   <= '0;
    end else begin
      a1_q    <= SNES_ADDR;
      r1_q    <= SNES_ROMSEL;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  // Priority select and translation. /ROMSEL is re-qualified with the stage-1
  // copy so a romsel_req change takes effect as soon as the translation does.
  always_comb begin
    rom_addr_d = '0;
    rom_hit_d  = 1'b0;
    saveram_d  = 1'b0;
    writable_d = 1'b0;
    win_hit_d  = '0;
    for (int i = 0; i < NUM_WIN; i++) begin
      if (!rom_hit_d && match_q[i] && (!ctrl_q[i][3] || !r1_q)) begin
        rom_hit_d    = 1'b1;
        win_hit_d[i] = 1'b1;
        rom_addr_d   = offset_q[i] + (a1_q & addr_mask_q[i]);
        saveram_d    = ctrl_q[i][2];
        writable_d   = ctrl_q[i][1];
      end
    end
  end

  // Stage 2 registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rom_addr_q   <= '0;
      rom_hit_q    <= 1'b0;
      saveram_q    <= 1'b0;
      writable_q   <= 1'b0;
      win_hit_q    <= '0;
      addr_valid_q <= 1'b0;
    end else begin
      rom_addr_q   <= rom_addr_d;
      rom_hit_q    <= rom_hit_d;
      saveram_q    <= saveram_d;
      writable_q   <= writable_d;
      win_hit_q    <= win_hit_d;
      addr_valid_q <= (cnt_q == SettleVal);
    end
  end

  assign ROM_ADDR    = rom_addr_q;
  assign ROM_HIT     = rom_hit_q;
  assign IS_SAVERAM  = saveram_q;
  assign IS_WRITABLE = writable_q;
  assign win_hit     = win_hit_q;
  assign addr_valid  = addr_valid_q;

endmodule

// File: tb/tb_gsu_window_map.sv
// Directed bench for gsu_window_map with default parameters (4 windows, settle 3).
module tb_gsu_window_map;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [2:0]  cfg_sel = '0;
  logic [23:0] cfg_data = '0;
  logic [23:0] SNES_ADDR = '0;
  logic        SNES_ROMSEL = 1'b0;
  logic [23:0] ROM_ADDR;
  logic        ROM_HIT;
  logic        IS_SAVERAM;
  logic        IS_WRITABLE;
  logic [3:0]  win_hit;
  logic        addr_valid;

  int n_checks = 0;
  int n_errors = 0;

  gsu_window_map #(
    .NUM_WIN(4),
    .SETTLE (3),
    .IDX_W  (2)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_sel    (cfg_sel),
    .cfg_data   (cfg_data),
    .SNES_ADDR  (SNES_ADDR),
    .SNES_ROMSEL(SNES_ROMSEL),
    .ROM_ADDR   (ROM_ADDR),
    .ROM_HIT    (ROM_HIT),
    .IS_SAVERAM (IS_SAVERAM),
    .IS_WRITABLE(IS_WRITABLE),
    .win_hit    (win_hit),
    .addr_valid (addr_valid)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One config write; returns just after the write edge
  task automatic cfg(input logic [1:0] idx, input logic [2:0] sel, input logic [23:0] data);
    cfg_we   = 1'b1;
    cfg_idx  = idx;
    cfg_sel  = sel;
    cfg_data = data;
    step(1);
    cfg_we   = 1'b0;
  endtask

  initial begin
    // Reset and empty map
    #2 RST_N = 1'b0;
    step(2);
    chk("rst_addr", 32'(ROM_ADDR), 32'h0);
    chk("rst_hit", 32'(ROM_HIT), 32'h0);
    chk("rst_win", 32'(win_hit), 32'h0);
    chk("rst_valid", 32'(addr_valid), 32'h0);
    RST_N = 1'b1;
    step(1);
    SNES_ADDR = 24'h408000;
    step(4);
    chk("empty_valid_e4", 32'(addr_valid), 32'h0);
    chk("empty_hit", 32'(ROM_HIT), 32'h0);
    step(1);
    chk("empty_valid_e5", 32'(addr_valid), 32'h1);
    SNES_ADDR = 24'hFFFFFF;
    step(1);
    chk("empty_valid_lag", 32'(addr_valid), 32'h1);
    step(1);
    chk("empty_valid_drop", 32'(addr_valid), 32'h0);
    chk("empty_ff_addr", 32'(ROM_ADDR), 32'h0);
    chk("empty_ff_win", 32'(win_hit), 32'h0);

    // Priority
    cfg(2'd0, 3'd0, 24'h700000);
    cfg(2'd0, 3'd1, 24'h7E0000);
    cfg(2'd0, 3'd2, 24'h01FFFF);
    cfg(2'd0, 3'd3, 24'hE00000);
    cfg(2'd0, 3'd4, 24'h000007);
    cfg(2'd1, 3'd0, 24'h400000);
    cfg(2'd1, 3'd1, 24'h400000);
    cfg(2'd1, 3'd2, 24'h3FFFFF);
    cfg(2'd1, 3'd3, 24'h000000);
    cfg(2'd1, 3'd4, 24'h000001);
    SNES_ADDR = 24'h701234;
    step(2);
    chk("w0_addr", 32'(ROM_ADDR), 32'hE01234);
    chk("w0_win", 32'(win_hit), 32'h1);
    chk("w0_hit", 32'(ROM_HIT), 32'h1);
    chk("w0_sav", 32'(IS_SAVERAM), 32'h1);
    chk("w0_wr", 32'(IS_WRITABLE), 32'h1);
    SNES_ADDR = 24'h451234;
    step(1);
    chk("lat_old_addr", 32'(ROM_ADDR), 32'hE01234);
    step(1);
    chk("w1_addr", 32'(ROM_ADDR), 32'h051234);
    chk("w1_win", 32'(win_hit), 32'h2);
    chk("w1_sav", 32'(IS_SAVERAM), 32'h0);
    chk("w1_wr", 32'(IS_WRITABLE), 32'h0);

    // romsel_req
    cfg(2'd1, 3'd4, 24'h000009);
    SNES_ROMSEL = 1'b1;
    step(6);
    chk("rs_miss_hit", 32'(ROM_HIT), 32'h0);
    chk("rs_miss_addr", 32'(ROM_ADDR), 32'h0);
    chk("rs_miss_win", 32'(win_hit), 32'h0);
    chk("rs_valid_pre", 32'(addr_valid), 32'h1);
    SNES_ROMSEL = 1'b0;
    step(1);
    chk("rs_valid_mid", 32'(addr_valid), 32'h1);
    step(1);
    chk("rs_hit", 32'(ROM_HIT), 32'h1);
    chk("rs_addr", 32'(ROM_ADDR), 32'h051234);
    chk("rs_valid_post", 32'(addr_valid), 32'h1);

    // Wrap-around
    cfg(2'd1, 3'd4, 24'h000001);
    cfg(2'd1, 3'd3, 24'hFF0000);
    cfg(2'd1, 3'd2, 24'h03FFFF);
    SNES_ADDR = 24'h420010;
    step(2);
    chk("wrap_addr", 32'(ROM_ADDR), 32'h010010);
    chk("wrap_win", 32'(win_hit), 32'h2);

    // Config write while stable
    cfg(2'd1, 3'd3, 24'h000000);
    cfg(2'd1, 3'd2, 24'h3FFFFF);
    SNES_ADDR = 24'h451234;
    step(6);
    chk("cw_valid0", 32'(addr_valid), 32'h1);
    chk("cw_addr0", 32'(ROM_ADDR), 32'h051234);
    cfg(2'd1, 3'd3, 24'h100000);
    step(1);
    chk("cw_valid_k1", 32'(addr_valid), 32'h0);
    step(1);
    chk("cw_addr_k2", 32'(ROM_ADDR), 32'h151234);
    step(1);
    chk("cw_valid_k3", 32'(addr_valid), 32'h0);
    step(1);
    chk("cw_valid_k4", 32'(addr_valid), 32'h1);
    cfg(2'd1, 3'd6, 24'h123456);
    step(2);
    chk("sel6_valid", 32'(addr_valid), 32'h1);
    chk("sel6_addr", 32'(ROM_ADDR), 32'h151234);

    // Reset mid-operation
    SNES_ADDR = 24'h701234;
    step(2);
    chk("pre_rst_win", 32'(win_hit), 32'h1);
    #3 RST_N = 1'b0;
    #1;
    chk("arst_addr", 32'(ROM_ADDR), 32'h0);
    chk("arst_hit", 32'(ROM_HIT), 32'h0);
    chk("arst_win", 32'(win_hit), 32'h0);
    chk("arst_sav", 32'(IS_SAVERAM), 32'h0);
    chk("arst_wr", 32'(IS_WRITABLE), 32'h0);
    chk("arst_valid", 32'(addr_valid), 32'h0);
    step(1);
    RST_N = 1'b1;
    step(3);
    chk("post_rst_hit", 32'(ROM_HIT), 32'h0);
    chk("post_rst_win", 32'(win_hit), 32'h0);

    // Catch-all window: zero match mask hits any address
    cfg(2'd3, 3'd3, 24'h000123);
    cfg(2'd3, 3'd4, 24'h000001);
    step(2);
    chk("catch_win", 32'(win_hit), 32'h8);
    chk("catch_addr", 32'(ROM_ADDR), 32'h000123);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
